// File: rtl/wb_register_file_if.sv
// MEM/WB-to-register-file bus: write-back inputs, ID/debug read ports, commit report.
interface wb_register_file_if #(
  parameter int CTRL_W = 25,
  parameter int DATA_W = 32
);
  logic [CTRL_W-1:0] control_signals;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_dest;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] dbg_data;
  logic              wb_commit;
  logic [4:0]        wb_commit_dest;

  modport master (
    output control_signals, wb_data, wb_dest, rs_addr, rt_addr, dbg_addr,
    input  rs_data, rt_data, dbg_data, wb_commit, wb_commit_dest
  );

  modport slave (
    input  control_signals, wb_data, wb_dest, rs_addr, rt_addr, dbg_addr,
    output rs_data, rt_data, dbg_data, wb_commit, wb_commit_dest
  );
endinterface

// File: rtl/wb_register_file.sv
// Write-back register file: 32x32 array, two bypassed ID read ports, one raw debug port,
// and a registered commit report.
module wb_register_file #(
  parameter int CTRL_W    = 25,
  parameter int RF_WE_BIT = 0,
  parameter int NREGS     = 32,
  parameter int DATA_W    = 32
) (
  input logic              clk,
  input logic              reset,
  wb_register_file_if.slave bus
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [CTRL_W-1:0]            ctrl;
  logic                         we;
  logic                         commit_q;
  logic [4:0]                   commit_dest_q;
  logic                         ctrl_unused;

  // Only the enable bit is consumed; the rest of the word is a lint sink.
  assign ctrl        = bus.control_signals;
  assign ctrl_unused = &{1'b0, ctrl};

  assign we = ctrl[RF_WE_BIT] & (bus.wb_dest != 5'd0) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs          <= '0;
      commit_q      <= 1'b0;
      commit_dest_q <= 5'd0;
    end else begin
      commit_q <= we;
      if (we) begin
        regs[bus.wb_dest] <= bus.wb_data;
        commit_dest_q     <= bus.wb_dest;
      end
    end
  end

  // Write-through: a WB write in flight this cycle wins over the stale array entry.
  function automatic logic [DATA_W-1:0] rd_bypass(input logic [4:0] addr);
    if (addr == 5'd0)                   return '0;
    else if (we && addr == bus.wb_dest) return bus.wb_data;
    else                                return regs[addr];
  endfunction

  assign bus.rs_data        = rd_bypass(bus.rs_addr);
  assign bus.rt_data        = rd_bypass(bus.rt_addr);
  assign bus.dbg_data       = (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];
  assign bus.wb_commit      = commit_q;
  assign bus.wb_commit_dest = commit_dest_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: reset sweep, vector table, mid-program reset.
module tb_wb_register_file;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_register_file_if #(.CTRL_W(25), .DATA_W(32)) bus ();

  wb_register_file #(.CTRL_W(25), .RF_WE_BIT(0), .NREGS(32), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [24:0] ctrl;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  rs, rt, dbg;
    logic [31:0] e_rs, e_rt, e_dbg;
    logic        e_cm;
    logic [4:0]  e_cd;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [24:0] c, input logic [4:0] d, input logic [31:0] v,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] g);
    bus.control_signals = c;
    bus.wb_dest         = d;
    bus.wb_data         = v;
    bus.rs_addr         = a;
    bus.rt_addr         = b;
    bus.dbg_addr        = g;
  endtask

  initial begin
    // Each row: inputs applied for one cycle; expected reads are same-cycle,
    // expected commit fields reflect the previous edge.
    //            ctrl          dest   data          rs     rt     dbg    e_rs          e_rt          e_dbg         cm    cd
    vecs[0]  = '{25'h0000001, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 5'd0};
    vecs[1]  = '{25'h0000000, 5'd5,  32'h0,        5'd0,  5'd5,  5'd5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd5};
    vecs[2]  = '{25'h0000001, 5'd8,  32'h11111111, 5'd8,  5'd3,  5'd8,  32'h11111111, 32'h0,        32'h0,        1'b0, 5'd5};
    vecs[3]  = '{25'h0000001, 5'd8,  32'h22222222, 5'd8,  5'd8,  5'd8,  32'h22222222, 32'h22222222, 32'h11111111, 1'b1, 5'd8};
    vecs[4]  = '{25'h0000000, 5'd0,  32'h0,        5'd8,  5'd5,  5'd8,  32'h22222222, 32'hDEADBEEF, 32'h22222222, 1'b1, 5'd8};
    vecs[5]  = '{25'h0000001, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  5'd0,  32'h0,        32'h22222222, 32'h0,        1'b0, 5'd8};
    vecs[6]  = '{25'h0000000, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 5'd8};
    vecs[7]  = '{25'h1FFFFFE, 5'd3,  32'h12345678, 5'd3,  5'd3,  5'd3,  32'h0,        32'h0,        32'h0,        1'b0, 5'd8};
    vecs[8]  = '{25'h0AAAAAA, 5'd3,  32'h12345678, 5'd3,  5'd5,  5'd3,  32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 5'd8};
    vecs[9]  = '{25'h1555555, 5'd3,  32'hCAFEF00D, 5'd3,  5'd8,  5'd3,  32'hCAFEF00D, 32'h22222222, 32'h0,        1'b0, 5'd8};
    vecs[10] = '{25'h0000001, 5'd3,  32'h0000BEEF, 5'd3,  5'd0,  5'd3,  32'h0000BEEF, 32'h0,        32'hCAFEF00D, 1'b1, 5'd3};
    vecs[11] = '{25'h0000001, 5'd31, 32'h80000001, 5'd3,  5'd31, 5'd3,  32'h0000BEEF, 32'h80000001, 32'h0000BEEF, 1'b1, 5'd3};
    vecs[12] = '{25'h0000000, 5'd0,  32'h0,        5'd31, 5'd5,  5'd31, 32'h80000001, 32'hDEADBEEF, 32'h80000001, 1'b1, 5'd31};
    vecs[13] = '{25'h0000000, 5'd0,  32'h0,        5'd31, 5'd8,  5'd5,  32'h80000001, 32'h22222222, 32'hDEADBEEF, 1'b0, 5'd31};

    // Reset held two cycles with a write presented, which must be dropped.
    reset = 1'b1;
    drive(25'h1, 5'd7, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(25'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("reset commit", {31'd0, bus.wb_commit}, 32'd0);
    chk("reset commit_dest", {27'd0, bus.wb_commit_dest}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #0.1;
      chk($sformatf("reset dbg r%0d", i), bus.dbg_data, 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].dest, vecs[i].data, vecs[i].rs, vecs[i].rt, vecs[i].dbg);
      #1;
      chk($sformatf("vec%0d rs_data", i), bus.rs_data, vecs[i].e_rs);
      chk($sformatf("vec%0d rt_data", i), bus.rt_data, vecs[i].e_rt);
      chk($sformatf("vec%0d dbg_data", i), bus.dbg_data, vecs[i].e_dbg);
      chk($sformatf("vec%0d wb_commit", i), {31'd0, bus.wb_commit}, {31'd0, vecs[i].e_cm});
      chk($sformatf("vec%0d commit_dest", i), {27'd0, bus.wb_commit_dest}, {27'd0, vecs[i].e_cd});
    end

    // Mid-program reset: r10 loaded, then reset coincides with another r10 write.
    @(negedge clk);
    drive(25'h1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd0, 5'd10);
    @(negedge clk);
    drive(25'h0, 5'd0, 32'h0, 5'd10, 5'd0, 5'd10);
    #1;
    chk("mid r10 loaded", bus.dbg_data, 32'hA5A5A5A5);
    chk("mid commit_dest", {27'd0, bus.wb_commit_dest}, 32'd10);
    @(negedge clk);
    reset = 1'b1;
    drive(25'h1, 5'd10, 32'h5A5A5A5A, 5'd10, 5'd10, 5'd10);
    #1;
    chk("reset gates bypass", bus.rs_data, 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b0;
    drive(25'h0, 5'd0, 32'h0, 5'd31, 5'd5, 5'd10);
    #1;
    chk("post reset r10", bus.dbg_data, 32'h0);
    chk("post reset r31", bus.rs_data, 32'h0);
    chk("post reset r5", bus.rt_data, 32'h0);
    chk("post reset commit", {31'd0, bus.wb_commit}, 32'd0);
    chk("post reset commit_dest", {27'd0, bus.wb_commit_dest}, 32'd0);
    @(negedge clk);
    drive(25'h1, 5'd10, 32'h00000007, 5'd0, 5'd0, 5'd10);
    @(negedge clk);
    drive(25'h0, 5'd0, 32'h0, 5'd10, 5'd0, 5'd10);
    #1;
    chk("rewrite r10 dbg", bus.dbg_data, 32'h7);
    chk("rewrite r10 rs", bus.rs_data, 32'h7);
    chk("rewrite commit", {31'd0, bus.wb_commit}, 32'd1);
    chk("rewrite commit_dest", {27'd0, bus.wb_commit_dest}, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back register file of the 5-stage MIPS core.
- Accepts the registered MEM/WB control word, result and destination, and commits the result into a 32x32 architectural register file.
- Serves two ID-stage read ports plus one debug/testbench read port.
- Provides write-through bypass so ID sees a same-cycle WB write without a separate forwarding path.

Parameters:
- CTRL_W, 25, width of the control word carried through the pipeline registers.
- RF_WE_BIT, 0, index in control_signals of the register-write-enable bit.
- NREGS, 32, number of architectural registers (address width fixed at 5).
- DATA_W, 32, register width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- control_signals  input  CTRL_W  WB-stage control word from MEM/WB; only bit RF_WE_BIT is used.
- wb_data  input  DATA_W  write-back result from MEM/WB.
- wb_dest  input  5  destination register number from MEM/WB.
- rs_addr  input  5  ID read port A address.
- rt_addr  input  5  ID read port B address.
- dbg_addr  input  5  debug read port address.
- rs_data  output  DATA_W  read port A data (combinational).
- rt_data  output  DATA_W  read port B data (combinational).
- dbg_data  output  DATA_W  debug read data (combinational, no bypass).
- wb_commit  output  1  registered pulse: a write was committed on the previous edge.
- wb_commit_dest  output  5  register number of that commit; holds its last value when wb_commit=0.

Behaviour:
- Write qualifier: we = control_signals[RF_WE_BIT] & (wb_dest != 0) & ~reset.
- Commit: at posedge clk, if we, regs[wb_dest] <= wb_data. Single write port; one write per cycle.
- Register 0: always reads 0. Writes to it are discarded and do not raise wb_commit.
- Reset (synchronous, active-high):
  - At the edge where reset=1, all 32 registers clear to 0, wb_commit <= 0, wb_commit_dest <= 0.
  - Any write presented in the same cycle is dropped.
  - Reset asserted mid-program discards architectural state completely; the first post-reset edge with we=1 commits normally.
- Reads on rs/rt ports: purely combinational from the array, with write-through bypass.
  - If we=1 and rs_addr==wb_dest, rs_data = wb_data (not the stale array value). Same rule for rt.
  - Both ports may bypass simultaneously when rs_addr==rt_addr==wb_dest.
  - Address 0 returns 0 even when wb_dest==0 and the enable bit is set.
- dbg port: reads the array only, with no bypass. A write is visible on dbg_data one edge after commit.
- Commit flag: at a non-reset edge, wb_commit <= we.
  - wb_commit_dest <= wb_dest when we=1; otherwise it holds its value.
  - Latency from WB-stage inputs to wb_commit is 1 cycle.
- Back-to-back writes to the same register: the last edge wins; the bypass always reflects the current-cycle input.
- Control bits other than RF_WE_BIT are ignored; X on unused bits must not propagate.
- No stall input: the register file always accepts. Flushes are expressed upstream by clearing the control word.

Test Plan:
1. Reset then read: hold reset 2 cycles, release; sweep dbg_addr 0..31 -> all dbg_data = 0x00000000, wb_commit=0.
2. Basic commit: we bit=1, wb_dest=5, wb_data=0xDEADBEEF for one cycle -> next cycle dbg_data(5)=0xDEADBEEF, wb_commit=1, wb_commit_dest=5; following idle cycle -> wb_commit=0, wb_commit_dest stays 5.
3. Bypass: array r8=0x11111111; present we=1, wb_dest=8, wb_data=0x22222222 with rs_addr=rt_addr=8 -> rs_data=rt_data=0x22222222 in the same cycle; dbg_data(8)=0x11111111 until the edge, then 0x22222222.
4. r0 protection: we=1, wb_dest=0, wb_data=0xFFFFFFFF, rs_addr=0 -> rs_data=0 in that cycle and after; wb_commit stays 0.
5. Enable off: we bit=0, wb_dest=3, wb_data=0x12345678, rs_addr=3 -> rs_data = old r3 (0); no commit; other control bits toggled randomly change nothing.
6. Reset mid-operation: r10=0xA5A5A5A5, then assert reset in the same cycle as we=1, wb_dest=10, wb_data=0x5A5A5A5A -> after the edge r10=0 and wb_commit=0; next write of 0x00000007 to r10 commits normally.
